// File: rtl/xor_stream_cipher.sv
// Flow-controlled XOR stream cipher: static, rolling or chained working key,
// one-beat output register, completion flag after the final beat drains.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | waiting for enable; key/shift/mode captured on exit
// ST_RUN   | accepting beats, encrypting into the output register
// ST_DRAIN | last beat accepted, waiting for its handoff
// ST_ABORT | enable dropped mid-run, flushing the pending output beat
// ST_DONE  | stream complete, led_complete high until enable drops
module xor_stream_cipher #(
  parameter int DATA_W  = 8,
  parameter int SHIFT_W = $clog2(DATA_W),
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               start_reset,
  input  logic               enable,
  input  logic [1:0]         mode,
  input  logic [SHIFT_W-1:0] shift,
  input  logic [DATA_W-1:0]  key,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [DATA_W-1:0]  s_data,
  input  logic               s_last,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [DATA_W-1:0]  m_data,
  output logic               m_last,
  output logic               led_complete,
  output logic [CNT_W-1:0]   beat_count
);

  typedef enum logic [2:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_ABORT, ST_DONE} state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   kreg_q, kreg_d;
  logic [1:0]          mode_q, mode_d;
  logic [SHIFT_W-1:0]  shift_q, shift_d;
  logic                m_valid_q, m_valid_d;
  logic                m_last_q, m_last_d;
  logic [DATA_W-1:0]   m_data_q, m_data_d;
  logic [CNT_W-1:0]    beat_count_q, beat_count_d;
  logic                accept;
  logic                handoff;

  // Doubling the word lets a plain left shift act as a rotate; n=0 yields x.
  function automatic logic [DATA_W-1:0] rotl(input logic [DATA_W-1:0] x,
                                              input logic [SHIFT_W-1:0] n);
    logic [2*DATA_W-1:0] t;
    t = {x, x} << (int'(n) % DATA_W);
    return t[2*DATA_W-1:DATA_W];
  endfunction

  always_ff @(posedge clk) begin
    if (start_reset) begin
      state_q      <= ST_IDLE;
      kreg_q       <= '0;
      mode_q       <= '0;
      shift_q      <= '0;
      m_valid_q    <= 1'b0;
      m_last_q     <= 1'b0;
      m_data_q     <= '0;
      beat_count_q <= '0;
    end else begin
      state_q      <= state_d;
      kreg_q       <= kreg_d;
      mode_q       <= mode_d;
      shift_q      <= shift_d;
      m_valid_q    <= m_valid_d;
      m_last_q     <= m_last_d;
      m_data_q     <= m_data_d;
      beat_count_q <= beat_count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (enable) state_d = ST_RUN;
      ST_RUN: begin
        if (accept && s_last)       state_d = ST_DRAIN;
        else if (!enable && !accept) state_d = ST_ABORT;
      end
      ST_DRAIN: if (handoff && m_last_q) state_d = ST_DONE;
      ST_ABORT: if (!m_valid_q || handoff) state_d = ST_IDLE;
      ST_DONE:  if (!enable) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    s_ready      = (state_q == ST_RUN) && (!m_valid_q || m_ready);
    led_complete = (state_q == ST_DONE);
    m_valid      = m_valid_q;
    m_last       = m_last_q;
    m_data       = m_data_q;
    beat_count   = beat_count_q;
  end

  assign accept  = s_ready && s_valid;
  assign handoff = m_valid_q && m_ready;

  always_comb begin
    kreg_d       = kreg_q;
    mode_d       = mode_q;
    shift_d      = shift_q;
    m_valid_d    = m_valid_q;
    m_last_d     = m_last_q;
    m_data_d     = m_data_q;
    beat_count_d = beat_count_q;
    if (state_q == ST_IDLE && enable) begin
      kreg_d       = rotl(key, shift);
      mode_d       = mode;
      shift_d      = shift;
      beat_count_d = '0;
    end
    if (accept) begin
      m_data_d  = s_data ^ kreg_q;
      m_last_d  = s_last;
      m_valid_d = 1'b1;
      if (beat_count_q != {CNT_W{1'b1}})
        beat_count_d = beat_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
      case (mode_q)
        2'd1:    kreg_d = rotl(kreg_q, shift_q);
        2'd2:    kreg_d = s_data ^ kreg_q;
        default: kreg_d = kreg_q;
      endcase
    end else if (handoff) begin
      m_valid_d = 1'b0;
      m_last_d  = 1'b0;
    end
  end

endmodule
